// File: rtl/wb2core.sv
// Wishbone B4 pipelined slave driving a core-side req/gnt/rvalid initiator, in-order responses.
// Define WB2CORE_RESP_REG_EN to register ack/err/dat_s (one extra cycle of response latency).
module wb2core #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_m,
  output logic [31:0] wb_dat_s,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall,
  output logic        core_req,
  output logic        core_we,
  output logic [3:0]  core_be,
  output logic [31:0] core_addr,
  output logic [31:0] core_wdata,
  input  logic        core_gnt,
  input  logic        core_rvalid,
  input  logic [31:0] core_rdata,
  input  logic        core_err
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            accept;
  logic            abort;
  logic            rsp_valid;
  logic [1:0]      dec;

  assign core_req   = wb_cyc & wb_stb & (count_q < CntMax) & (state_q != StDrain);
  assign core_we    = wb_we;
  assign core_be    = wb_sel;
  assign core_addr  = {wb_adr[31:2], 2'b00};
  assign core_wdata = wb_dat_m;

  assign accept   = core_req & core_gnt;
  assign wb_stall = wb_cyc & wb_stb & ~accept;
  // Responses to an abandoned cycle are swallowed without a bus pulse.
  assign abort    = (state_q == StDrain) | ~wb_cyc;

`ifdef WB2CORE_RESP_REG_EN
  logic        ack_q, err_q;
  logic [31:0] dat_q;
  logic        pend;

  assign pend = ack_q | err_q;
  // A response held in the output stage is still part of count_q.
  assign rsp_valid = core_rvalid & (count_q > CntW'(pend));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= rsp_valid & ~abort & ~core_err;
      err_q <= rsp_valid & ~abort & core_err;
      if (rsp_valid & ~abort & ~core_err) begin
        dat_q <= core_rdata;
      end
    end
  end

  assign wb_ack   = ack_q;
  assign wb_err   = err_q;
  assign wb_dat_s = dat_q;
  assign dec      = {1'b0, pend} + {1'b0, rsp_valid & abort};
`else
  assign rsp_valid = core_rvalid & (count_q != '0);
  assign wb_ack    = rsp_valid & ~abort & ~core_err;
  assign wb_err    = rsp_valid & ~abort & core_err;
  assign wb_dat_s  = wb_ack ? core_rdata : '0;
  assign dec       = {1'b0, rsp_valid};
`endif

  always_comb begin
    count_d = count_q + CntW'(accept) - CntW'(dec);
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StActive;
      end
      StActive: begin
        if (!wb_cyc) begin
          state_d = (count_d != '0) ? StDrain : StIdle;
        end else if (count_d == '0) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (count_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_wb2core.sv
// Directed self-checking bench for wb2core (MaxOutstanding=2); follows WB2CORE_RESP_REG_EN.
module tb_wb2core;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_m, wb_dat_s;
  logic        wb_ack, wb_err, wb_stall;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_gnt, core_rvalid, core_err;

  always #5 clk = ~clk;

  wb2core #(.MaxOutstanding(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_adr     (wb_adr),
    .wb_dat_m   (wb_dat_m),
    .wb_dat_s   (wb_dat_s),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .wb_stall   (wb_stall),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_be    (core_be),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .core_err   (core_err)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          ack_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] ack_data[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_ack) begin
        ack_cnt++;
        ack_data.push_back(wb_dat_s);
      end
      if (wb_err) err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 4'hF; wb_adr = '0; wb_dat_m = '0;
    core_gnt = 0; core_rvalid = 0; core_rdata = '0; core_err = 0;
  endtask

  // Single read on an open cycle: gnt immediately, rvalid the next cycle.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic e);
    step(); wb_stb = 1; wb_we = 0; wb_adr = a; core_gnt = 1;
    step(); wb_stb = 0; core_gnt = 0; core_rvalid = 1; core_rdata = d; core_err = e;
    step(); core_rvalid = 0; core_err = 0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1;
    idle_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (core_req !== 1'b0) $display("FAIL rst_req: got %b want 0", core_req); else n_pass++;
    n_total++; if (wb_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", wb_stall); else n_pass++;
    n_total++; if (wb_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", wb_ack); else n_pass++;
    n_total++; if (wb_err !== 1'b0) $display("FAIL rst_err: got %b want 0", wb_err); else n_pass++;
    n_total++;
    if (wb_dat_s !== 32'h0) $display("FAIL rst_dat: got %h want 0", wb_dat_s); else n_pass++;
    n_total++;
    if (dut.count_q !== 2'd0) $display("FAIL rst_count: got %0d want 0", dut.count_q); else n_pass++;
    step();
    rst = 0;
    step();
  endtask

  task automatic test_single_read();
    int base;
    base = ack_data.size();
    step(); wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_sel = 4'hF; wb_adr = 32'h100; core_gnt = 1;
    @(negedge clk);
    n_total++; if (core_req !== 1'b1) $display("FAIL rd_req: got %b want 1", core_req); else n_pass++;
    n_total++; if (wb_stall !== 1'b0) $display("FAIL rd_stall: got %b want 0", wb_stall); else n_pass++;
    n_total++;
    if (core_addr !== 32'h100) $display("FAIL rd_addr: got %h want 100", core_addr); else n_pass++;
    step(); wb_stb = 0; core_gnt = 0; core_rvalid = 1; core_rdata = 32'hDEADBEEF;
    @(negedge clk);
`ifdef WB2CORE_RESP_REG_EN
    n_total++; if (wb_ack !== 1'b0) $display("FAIL rd_ack_early: got %b want 0", wb_ack); else n_pass++;
`else
    n_total++; if (wb_ack !== 1'b1) $display("FAIL rd_ack_comb: got %b want 1", wb_ack); else n_pass++;
    n_total++;
    if (wb_dat_s !== 32'hDEADBEEF) $display("FAIL rd_dat_comb: got %h want deadbeef", wb_dat_s);
    else n_pass++;
`endif
    step(); core_rvalid = 0;
    @(negedge clk);
`ifdef WB2CORE_RESP_REG_EN
    n_total++; if (wb_ack !== 1'b1) $display("FAIL rd_ack_reg: got %b want 1", wb_ack); else n_pass++;
    n_total++;
    if (wb_dat_s !== 32'hDEADBEEF) $display("FAIL rd_dat_reg: got %h want deadbeef", wb_dat_s);
    else n_pass++;
`else
    n_total++; if (wb_ack !== 1'b0) $display("FAIL rd_ack_once: got %b want 0", wb_ack); else n_pass++;
`endif
    step(); step();
    n_total++;
    if (ack_data.size() - base != 1) $display("FAIL rd_nack: got %0d want 1", ack_data.size() - base);
    else n_pass++;
    wb_cyc = 0;
  endtask

  task automatic test_write_stall();
    int base, ebase, stall_cyc;
    base = ack_data.size(); ebase = err_cnt; stall_cyc = 0;
    step(); wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_sel = 4'h3; wb_adr = 32'h20E;
    wb_dat_m = 32'h1234; core_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_stall) stall_cyc++;
      step();
    end
    core_gnt = 1;
    @(negedge clk);
    n_total++; if (stall_cyc != 3) $display("FAIL wr_stall_cyc: got %0d want 3", stall_cyc); else n_pass++;
    n_total++; if (wb_stall !== 1'b0) $display("FAIL wr_stall_gnt: got %b want 0", wb_stall); else n_pass++;
    n_total++; if (core_be !== 4'h3) $display("FAIL wr_be: got %h want 3", core_be); else n_pass++;
    n_total++;
    if (core_wdata !== 32'h1234) $display("FAIL wr_wdata: got %h want 1234", core_wdata); else n_pass++;
    n_total++;
    if (core_addr !== 32'h20C) $display("FAIL wr_addr: got %h want 20c", core_addr); else n_pass++;
    n_total++; if (core_we !== 1'b1) $display("FAIL wr_we: got %b want 1", core_we); else n_pass++;
    step(); wb_stb = 0; core_gnt = 0; core_rvalid = 1; core_rdata = 32'h0;
    step(); core_rvalid = 0;
    step(); step();
    n_total++;
    if (ack_data.size() - base != 1) $display("FAIL wr_nack: got %0d want 1", ack_data.size() - base);
    else n_pass++;
    n_total++; if (err_cnt != ebase) $display("FAIL wr_nerr: got %0d want 0", err_cnt - ebase); else n_pass++;
    wb_cyc = 0; wb_we = 0; wb_sel = 4'hF;
  endtask

  task automatic test_pipelined();
    logic [31:0] a_tab[4];
    logic [31:0] d_tab[4];
    int base, sent, resp, cyc_n, first_stall, third_resp, full_rsp, full_bad;
    a_tab = '{32'h400, 32'h404, 32'h408, 32'h40C};
    d_tab = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003};
    base = ack_data.size(); sent = 0; resp = 0; cyc_n = 0;
    first_stall = -1; third_resp = -1; full_rsp = 0; full_bad = 0;
    step(); wb_cyc = 1;
    while ((sent < 4 || resp < 4) && cyc_n < 60) begin
      wb_stb = (sent < 4); wb_we = 0; wb_adr = a_tab[sent % 4]; core_gnt = 1;
      core_rvalid = (sent - resp > 0) && (cyc_n % 3 == 2);
      core_rdata = d_tab[resp % 4];
      @(negedge clk);
      if (wb_stb && core_rvalid && (sent - resp == 2)) begin
        full_rsp++;
        if (!wb_stall) full_bad++;
      end
      if (wb_stb && wb_stall && first_stall < 0) first_stall = sent;
      if (wb_stb && !wb_stall) begin
        if (sent == 2) third_resp = resp;
        sent++;
      end
      if (core_rvalid) resp++;
      cyc_n++;
      step();
    end
    wb_stb = 0; core_gnt = 0; core_rvalid = 0;
    step(); step();
    n_total++; if (cyc_n >= 60) $display("FAIL pipe_timeout: got %0d want <60", cyc_n); else n_pass++;
    n_total++;
    if (first_stall != 2) $display("FAIL pipe_first_stall: got %0d want 2", first_stall); else n_pass++;
    n_total++;
    if (third_resp < 1) $display("FAIL pipe_third_early: got %0d want >=1", third_resp); else n_pass++;
    n_total++;
    if (full_rsp == 0 || full_bad != 0)
      $display("FAIL pipe_full_rsp: got %0d unstalled of %0d want 0 of >0", full_bad, full_rsp);
    else n_pass++;
    n_total++;
    if (ack_data.size() - base != 4)
      $display("FAIL pipe_nack: got %0d want 4", ack_data.size() - base);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (ack_data.size() < base + i + 1)
        $display("FAIL pipe_data%0d: got none want %h", i, d_tab[i]);
      else if (ack_data[base + i] !== d_tab[i])
        $display("FAIL pipe_data%0d: got %h want %h", i, ack_data[base + i], d_tab[i]);
      else n_pass++;
    end
    wb_cyc = 0;
  endtask

  task automatic test_error();
    int base, ebase;
    base = ack_data.size(); ebase = err_cnt;
    step(); wb_cyc = 1;
    do_read(32'h300, 32'hBAD0BAD0, 1'b1);
    n_total++; if (err_cnt - ebase != 1) $display("FAIL err_nerr: got %0d want 1", err_cnt - ebase); else n_pass++;
    n_total++;
    if (ack_data.size() != base) $display("FAIL err_nack: got %0d want 0", ack_data.size() - base);
    else n_pass++;
    do_read(32'h304, 32'hA5A5A5A5, 1'b0);
    n_total++;
    if (ack_data.size() - base != 1) $display("FAIL err_next_ack: got %0d want 1", ack_data.size() - base);
    else n_pass++;
    n_total++;
    if (ack_data.size() == base + 1 && ack_data[base] !== 32'hA5A5A5A5)
      $display("FAIL err_next_dat: got %h want a5a5a5a5", ack_data[base]);
    else n_pass++;
    n_total++; if (err_cnt - ebase != 1) $display("FAIL err_once: got %0d want 1", err_cnt - ebase); else n_pass++;
    wb_cyc = 0;
  endtask

  task automatic test_abort();
    int base, ebase, stall_cyc;
    logic acc;
    base = ack_data.size(); ebase = err_cnt; stall_cyc = 0; acc = 0;
    step(); wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h500; core_gnt = 1;
    step(); wb_adr = 32'h504;
    step(); wb_cyc = 0; wb_stb = 0; core_gnt = 0;
    step(); wb_cyc = 1; wb_stb = 1; wb_adr = 32'h600; core_gnt = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_stall && !core_req) stall_cyc++;
      step();
    end
    core_rvalid = 1; core_rdata = 32'hEEEE0001;
    @(negedge clk);
    n_total++; if (wb_stall !== 1'b1) $display("FAIL abort_stall_rsp: got %b want 1", wb_stall); else n_pass++;
    step(); core_rdata = 32'hEEEE0002;
    @(negedge clk);
    step(); core_rvalid = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      if (!wb_stall) acc = 1;
      else step();
    end
    n_total++; if (stall_cyc != 3) $display("FAIL abort_stall: got %0d want 3", stall_cyc); else n_pass++;
    n_total++; if (!acc) $display("FAIL abort_accept: got 0 want 1"); else n_pass++;
    n_total++;
    if (ack_data.size() != base) $display("FAIL abort_silent_ack: got %0d want 0", ack_data.size() - base);
    else n_pass++;
    n_total++;
    if (err_cnt != ebase) $display("FAIL abort_silent_err: got %0d want 0", err_cnt - ebase); else n_pass++;
    step(); wb_stb = 0; core_gnt = 0; core_rvalid = 1; core_rdata = 32'h600D600D;
    step(); core_rvalid = 0;
    step(); step();
    n_total++;
    if (ack_data.size() - base != 1 || ack_data[ack_data.size() - 1] !== 32'h600D600D)
      $display("FAIL abort_next: got %0d acks want 1 with 600d600d", ack_data.size() - base);
    else n_pass++;
    wb_cyc = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    step(); wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h700; core_gnt = 1;
    step(); wb_adr = 32'h704;
    step(); wb_stb = 0; core_gnt = 0;
    @(negedge clk);
    n_total++;
    if (dut.count_q !== 2'd2) $display("FAIL mid_count_pre: got %0d want 2", dut.count_q); else n_pass++;
    #2 rst = 1;
    #1;
    n_total++;
    if (dut.count_q !== 2'd0) $display("FAIL mid_count: got %0d want 0", dut.count_q); else n_pass++;
    n_total++;
    if (dut.state_q !== 2'd0) $display("FAIL mid_state: got %0d want 0", dut.state_q); else n_pass++;
    n_total++;
    if (wb_ack !== 1'b0 || wb_err !== 1'b0)
      $display("FAIL mid_ackerr: got %b%b want 00", wb_ack, wb_err);
    else n_pass++;
    step(); rst = 0;
    base = ack_data.size();
    wb_stb = 1; wb_adr = 32'h708; core_gnt = 1;
    @(negedge clk);
    n_total++; if (core_req !== 1'b1) $display("FAIL mid_req_after: got %b want 1", core_req); else n_pass++;
    step(); wb_stb = 0; core_gnt = 0; core_rvalid = 1; core_rdata = 32'hC0FFEE00;
    step(); core_rvalid = 0;
    step(); step();
    n_total++;
    if (ack_data.size() - base != 1 || ack_data[ack_data.size() - 1] !== 32'hC0FFEE00)
      $display("FAIL mid_next: got %0d acks want 1 with c0ffee00", ack_data.size() - base);
    else n_pass++;
    wb_cyc = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_stall();
    test_pipelined();
    test_error();
    test_abort();
    test_reset_mid();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb2core.md
# wb2core

Wishbone B4 pipelined slave that converts bus cycles into the core-side req/gnt/rvalid memory protocol. It is the responder counterpart of the core-to-Wishbone bridge. It lets an Ibex-style memory, or any peripheral built on the core handshake, be attached as a Wishbone slave. Responses are returned strictly in order, with a bounded number of outstanding transactions and clean handling of aborted cycles.

## Interface
- `MaxOutstanding`, default 2: maximum accepted-but-unanswered requests; legal range 1..15.
- `clk` in 1: clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `wb` wb_if.slave: Wishbone B4 pipelined slave.
  - Inputs: cyc, stb, we, sel[3:0], adr[31:0], dat_m[31:0].
  - Outputs: dat_s[31:0], ack, err, stall.
- `core` core_if.master: memory-side initiator.
  - Outputs: req, we, be[3:0], addr[31:0], wdata[31:0].
  - Inputs: gnt, rvalid, rdata[31:0], err.

## Operation
- State machine:
  - IDLE → ACTIVE on the first accepted request.
  - ACTIVE → IDLE when cyc=1 and count reaches 0.
  - ACTIVE → DRAIN when cyc drops while count>0.
  - DRAIN → IDLE when count reaches 0.
- `count` is an outstanding-request counter, width $clog2(MaxOutstanding+1).
  - +1 on accept (`req & gnt`).
  - −1 on response delivered.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding; never underflows. An rvalid arriving with count=0 is ignored.
- Request path (combinational):
  - `core.req = wb.cyc & wb.stb & (count<MaxOutstanding) & state!=DRAIN`.
  - `core.we`, `core.be`, `core.addr`, `core.wdata` are driven from wb.we, wb.sel, wb.adr, wb.dat_m.
  - `core.addr` is forwarded with bits [1:0] forced to 0.
- `wb.stall = wb.cyc & wb.stb & ~(core.req & core.gnt)`.
- Response path:
  - Each rvalid produces exactly one ack or err pulse. Writes are acknowledged the same way.
  - core.err=1 → wb.err=1, wb.ack=0. Otherwise wb.ack=1.
  - wb.dat_s = core.rdata on read acks. wb.dat_s is don't-care for writes and may carry rdata.
- Abort: when cyc deasserts with requests outstanding, the remaining rvalids are consumed silently (no ack/err). While in DRAIN, a new cyc/stb is stalled until count=0.

## Timing
- Reset values: state IDLE, count 0, wb.ack 0, wb.err 0, wb.dat_s 0. With cyc=0: core.req 0, wb.stall 0.
- Request acceptance is zero-cycle: a request is accepted in the cycle where stb=1 and stall=0.
- Response latency, macro undefined: ack/err is combinational in the same cycle as core.rvalid.
- Response latency, macro defined: ack/err is registered, one cycle after core.rvalid.
- Back-to-back accepts are allowed every cycle up to MaxOutstanding.
- Count full and a response in the same cycle: the new request is still stalled. Full is evaluated on the registered count.
- Reset asserted mid-transaction: all state clears immediately and pending responses are lost. The bench must not deliver rvalid after a reset for requests made before it.

## Configuration
- `WB2CORE_RESP_REG_EN` defined:
  - wb.ack, wb.err and wb.dat_s come from flops, breaking the rdata→dat_s combinational path.
  - count decrements when the registered ack/err is issued.
  - In DRAIN, the registered stage is suppressed.
- `WB2CORE_RESP_REG_EN` undefined: fully combinational response path, zero added latency.

## Test plan
- Single read, adr=0x100, gnt the same cycle, rvalid 1 cycle later with rdata=0xDEADBEEF → one ack, dat_s=0xDEADBEEF (+1 cycle with macro), core.addr=0x100.
- Write with sel=0x3, dat_m=0x1234 and gnt delayed 3 cycles → stall high for 3 cycles, core.be=0x3, core.wdata=0x1234, exactly one ack.
- MaxOutstanding=2, 4 pipelined reads with gnt always 1 and rvalid delayed → third stb stalled until the first response; 4 acks in order.
- rvalid with core.err=1 → wb.err pulse, no ack; next transaction completes normally.
- Abort: 2 reads accepted, cyc drops, new cyc starts immediately → new stb stalled until 2 rvalids drained; no ack/err emitted for the aborted pair.
- Reset asserted mid-burst with count=2 → count 0, ack/err 0, state IDLE in the same cycle; a next cycle works normally.
